// File: rtl/hood_pkg.sv
// hood_pkg: shared definitions for the kitchen-hood mode sequencer.
//   mode_e        - modestate encodings driven to the display path
//   FAN_*         - fan speed codes
//   KEY_*         - bit positions in the packed key vector; a higher index
//                   means a higher priority when keys arrive together
//   mmss_t        - minutes/seconds pair used by the countdown
//   sec_to_mmss   - splits a whole-second duration into mm:ss
//   fan_for_mode  - fan speed driven in each mode
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'b000,
    MODE_STANDBY = 3'b001,
    MODE_L1      = 3'b010,
    MODE_L2      = 3'b011,
    MODE_L3      = 3'b101,
    MODE_EXHAUST = 3'b110,
    MODE_CLEAN   = 3'b100
  } mode_e;

  localparam logic [1:0] FAN_OFF  = 2'd0;
  localparam logic [1:0] FAN_LOW  = 2'd1;
  localparam logic [1:0] FAN_MID  = 2'd2;
  localparam logic [1:0] FAN_HIGH = 2'd3;

  // Key vector layout, lowest priority at bit 0.
  localparam int KEY_L1    = 0;
  localparam int KEY_L2    = 1;
  localparam int KEY_L3    = 2;
  localparam int KEY_CLEAN = 3;
  localparam int KEY_MENU  = 4;
  localparam int KEY_POWER = 5;
  localparam int NUM_KEYS  = 6;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
  } mmss_t;

  function automatic mmss_t sec_to_mmss(input int unsigned total);
    mmss_t r;
    r.min = 6'(total / 32'd60);
    r.sec = 6'(total % 32'd60);
    return r;
  endfunction

  function automatic logic [1:0] fan_for_mode(input mode_e m);
    logic [1:0] f;
    case (m)
      MODE_L1:      f = FAN_LOW;
      MODE_L2:      f = FAN_MID;
      MODE_L3:      f = FAN_HIGH;
      MODE_EXHAUST: f = FAN_MID;
      default:      f = FAN_OFF;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/hood_mode_ctrl_countdown.sv
// sec_countdown: shared mm:ss down-counter with a 1-second tick divider.
//   clk, rst     - clock, synchronous active-high reset
//   load         - start a new countdown from load_val (divider restarts)
//   stop         - abandon the countdown, return to 0:00 idle
//   load_val     - mm:ss start value
//   remain_min   - registered minutes remaining
//   remain_sec   - registered seconds remaining
//   running      - registered, high while counting
//   expire       - combinational, high during the cycle whose tick takes
//                  0:01 to 0:00, so the owner can switch state on that edge
module sec_countdown
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       stop,
  input  mmss_t      load_val,
  output logic [5:0] remain_min,
  output logic [5:0] remain_sec,
  output logic       running,
  output logic       expire
);

  localparam int unsigned DIV_W = (CLK_HZ > 32'd1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] div_r;
  logic             tick_s;

  // Tick at divider terminal count; expiry is the tick that reaches 0:00.
  always_comb begin
    tick_s = 1'b0;
    expire = 1'b0;
    if (running && (div_r == DIV_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (tick_s && (remain_min == 6'd0) && (remain_sec == 6'd1)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Divider and mm:ss register update; load wins over everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r      <= DIV_ZERO;
      remain_min <= 6'd0;
      remain_sec <= 6'd0;
      running    <= 1'b0;
    end else if (load) begin
      div_r      <= DIV_ZERO;
      remain_min <= load_val.min;
      remain_sec <= load_val.sec;
      running    <= 1'b1;
    end else if (stop || expire) begin
      div_r      <= DIV_ZERO;
      remain_min <= 6'd0;
      remain_sec <= 6'd0;
      running    <= 1'b0;
    end else if (tick_s) begin
      div_r <= DIV_ZERO;
      if (remain_sec != 6'd0) begin
        remain_sec <= remain_sec - 6'd1;
      end else if (remain_min != 6'd0) begin
        // Minute borrow: m:00 -> (m-1):59.
        remain_sec <= 6'd59;
        remain_min <= remain_min - 6'd1;
      end else begin
        // Loaded with 0:00; nothing left to count.
        running <= 1'b0;
      end
    end else if (running) begin
      div_r <= div_r + DIV_ONE;
    end else begin
      div_r <= DIV_ZERO;
    end
  end

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: kitchen-hood mode sequencer.
//   clk, rst               - clock, synchronous active-high reset
//   power_key, menu_key    - one-cycle key pulses (power toggle, back to standby)
//   l1_key, l2_key, l3_key - one-cycle key pulses, fan level select
//   clean_key              - one-cycle key pulse, start self-clean
//   modestate              - registered current mode (hood_pkg::mode_e encoding)
//   fan_level              - registered fan speed 0..3
//   remain_min, remain_sec - registered countdown for timed modes
//   timer_run              - registered, high while a timed mode counts
//   clean_done             - registered one-cycle pulse on self-clean completion
// Keys act one cycle later; when several arrive together only the highest
// priority key that is meaningful in the current mode acts.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned CLEAN_SEC   = 180,
  parameter int unsigned STORM_SEC   = 60,
  parameter int unsigned EXHAUST_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_key,
  input  logic       menu_key,
  input  logic       l1_key,
  input  logic       l2_key,
  input  logic       l3_key,
  input  logic       clean_key,
  output logic [2:0] modestate,
  output logic [1:0] fan_level,
  output logic [5:0] remain_min,
  output logic [5:0] remain_sec,
  output logic       timer_run,
  output logic       clean_done
);

  localparam mmss_t CLEAN_MMSS   = sec_to_mmss(CLEAN_SEC);
  localparam mmss_t STORM_MMSS   = sec_to_mmss(STORM_SEC);
  localparam mmss_t EXHAUST_MMSS = sec_to_mmss(EXHAUST_SEC);

  mode_e               state_r;
  mode_e               next_s;
  logic [1:0]          fan_r;
  logic                done_r;
  logic                done_s;
  logic [NUM_KEYS-1:0] keys_s;
  logic                expire_s;
  logic                load_s;
  logic                stop_s;
  mmss_t               load_val_s;

  assign keys_s = {power_key, menu_key, clean_key, l3_key, l2_key, l1_key};

  // Next-mode decision: per-mode priority chain, keys before timer expiry.
  always_comb begin
    next_s = state_r;
    done_s = 1'b0;
    case (state_r)
      MODE_OFF: begin
        if (keys_s[KEY_POWER]) next_s = MODE_STANDBY;
        else                   next_s = state_r;
      end
      MODE_STANDBY: begin
        if (keys_s[KEY_POWER])      next_s = MODE_OFF;
        else if (keys_s[KEY_CLEAN]) next_s = MODE_CLEAN;
        else if (keys_s[KEY_L3])    next_s = MODE_L3;
        else if (keys_s[KEY_L2])    next_s = MODE_L2;
        else if (keys_s[KEY_L1])    next_s = MODE_L1;
        else                        next_s = state_r;
      end
      MODE_L1, MODE_L2: begin
        if (keys_s[KEY_POWER])     next_s = MODE_OFF;
        else if (keys_s[KEY_MENU]) next_s = MODE_STANDBY;
        else if (keys_s[KEY_L3])   next_s = MODE_L3;
        else if (keys_s[KEY_L2])   next_s = MODE_L2;
        else if (keys_s[KEY_L1])   next_s = MODE_L1;
        else                       next_s = state_r;
      end
      MODE_L3: begin
        // l3 while already in L3 keeps the running storm timer.
        if (keys_s[KEY_POWER])     next_s = MODE_OFF;
        else if (keys_s[KEY_MENU]) next_s = MODE_EXHAUST;
        else if (expire_s)         next_s = MODE_L2;
        else                       next_s = state_r;
      end
      MODE_EXHAUST: begin
        if (keys_s[KEY_POWER]) next_s = MODE_OFF;
        else if (expire_s)     next_s = MODE_STANDBY;
        else                   next_s = state_r;
      end
      MODE_CLEAN: begin
        // Power aborts silently; only natural completion reports done.
        if (keys_s[KEY_POWER]) begin
          next_s = MODE_OFF;
          done_s = 1'b0;
        end else if (expire_s) begin
          next_s = MODE_STANDBY;
          done_s = 1'b1;
        end else begin
          next_s = state_r;
          done_s = 1'b0;
        end
      end
      default: begin
        next_s = MODE_OFF;
        done_s = 1'b0;
      end
    endcase
  end

  // Countdown control: load on entry into a timed mode, idle elsewhere.
  always_comb begin
    load_s     = 1'b0;
    stop_s     = 1'b0;
    load_val_s = '{min: 6'd0, sec: 6'd0};
    case (next_s)
      MODE_L3: begin
        load_val_s = STORM_MMSS;
        if (state_r != MODE_L3) load_s = 1'b1;
        else                    load_s = 1'b0;
      end
      MODE_EXHAUST: begin
        load_val_s = EXHAUST_MMSS;
        if (state_r != MODE_EXHAUST) load_s = 1'b1;
        else                         load_s = 1'b0;
      end
      MODE_CLEAN: begin
        load_val_s = CLEAN_MMSS;
        if (state_r != MODE_CLEAN) load_s = 1'b1;
        else                       load_s = 1'b0;
      end
      default: begin
        stop_s = 1'b1;
      end
    endcase
  end

  // Mode register and the outputs derived from the next mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MODE_OFF;
      fan_r   <= FAN_OFF;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      fan_r   <= fan_for_mode(next_s);
      done_r  <= done_s;
    end
  end

  sec_countdown #(
    .CLK_HZ(CLK_HZ)
  ) u_countdown (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .stop       (stop_s),
    .load_val   (load_val_s),
    .remain_min (remain_min),
    .remain_sec (remain_sec),
    .running    (timer_run),
    .expire     (expire_s)
  );

  assign modestate  = state_r;
  assign fan_level  = fan_r;
  assign clean_done = done_r;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed scenarios plus random key traffic against a
// seconds-based reference model. Two instances share the stimulus: dut0 uses
// a 3-second self-clean, dut1 a 61-second one to exercise the minute borrow.
module tb_hood_mode_ctrl;

  localparam int HZ = 10;

  localparam logic [5:0] K_NONE  = 6'b000000;
  localparam logic [5:0] K_PWR   = 6'b100000;
  localparam logic [5:0] K_MENU  = 6'b010000;
  localparam logic [5:0] K_CLEAN = 6'b001000;
  localparam logic [5:0] K_L3    = 6'b000100;
  localparam logic [5:0] K_L2    = 6'b000010;
  localparam logic [5:0] K_L1    = 6'b000001;

  // Model mode names (independent of the hardware encoding).
  localparam int M_OFF = 0, M_SB = 1, M_L1 = 2, M_L2 = 3, M_L3 = 4, M_EX = 5, M_CL = 6;

  logic clk;
  logic rst;
  logic power_key, menu_key, l1_key, l2_key, l3_key, clean_key;

  logic [2:0]  ms [2];
  logic [1:0]  fl [2];
  logic [5:0]  rm [2];
  logic [5:0]  rs [2];
  logic        tr [2];
  logic        cd [2];
  logic [18:0] act [2];

  int n_vec = 0;
  int n_err = 0;

  int m_mode [2];
  int m_left [2];
  int m_cyc  [2];
  bit m_done [2];
  int clean_len [2] = '{3, 61};

  hood_mode_ctrl #(.CLK_HZ(HZ), .CLEAN_SEC(3), .STORM_SEC(2), .EXHAUST_SEC(2)) dut0 (
    .clk(clk), .rst(rst), .power_key(power_key), .menu_key(menu_key),
    .l1_key(l1_key), .l2_key(l2_key), .l3_key(l3_key), .clean_key(clean_key),
    .modestate(ms[0]), .fan_level(fl[0]), .remain_min(rm[0]), .remain_sec(rs[0]),
    .timer_run(tr[0]), .clean_done(cd[0]));

  hood_mode_ctrl #(.CLK_HZ(HZ), .CLEAN_SEC(61), .STORM_SEC(2), .EXHAUST_SEC(2)) dut1 (
    .clk(clk), .rst(rst), .power_key(power_key), .menu_key(menu_key),
    .l1_key(l1_key), .l2_key(l2_key), .l3_key(l3_key), .clean_key(clean_key),
    .modestate(ms[1]), .fan_level(fl[1]), .remain_min(rm[1]), .remain_sec(rs[1]),
    .timer_run(tr[1]), .clean_done(cd[1]));

  assign act[0] = {ms[0], fl[0], rm[0], rs[0], tr[0], cd[0]};
  assign act[1] = {ms[1], fl[1], rm[1], rs[1], tr[1], cd[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_timed(input int m);
    return (m == M_L3) || (m == M_EX) || (m == M_CL);
  endfunction

  function automatic int duration(input int i, input int m);
    if (m == M_L3) return 2;
    if (m == M_EX) return 2;
    return clean_len[i];
  endfunction

  function automatic int next_mode(input int m, input logic [5:0] k, input bit ex);
    case (m)
      M_OFF:      return k[5] ? M_SB : M_OFF;
      M_SB:       return k[5] ? M_OFF : k[3] ? M_CL : k[2] ? M_L3 : k[1] ? M_L2 : k[0] ? M_L1 : M_SB;
      M_L1, M_L2: return k[5] ? M_OFF : k[4] ? M_SB : k[2] ? M_L3 : k[1] ? M_L2 : k[0] ? M_L1 : m;
      M_L3:       return k[5] ? M_OFF : k[4] ? M_EX : ex ? M_L2 : M_L3;
      M_EX:       return k[5] ? M_OFF : ex ? M_SB : M_EX;
      M_CL:       return k[5] ? M_OFF : ex ? M_SB : M_CL;
      default:    return M_OFF;
    endcase
  endfunction

  task automatic model_step(input int i, input logic [5:0] k, input logic r);
    int nxt;
    bit ex;
    if (r) begin
      m_mode[i] = M_OFF; m_left[i] = 0; m_cyc[i] = 0; m_done[i] = 1'b0;
      return;
    end
    ex = is_timed(m_mode[i]) && (m_cyc[i] + 1 == HZ) && (m_left[i] == 1);
    nxt = next_mode(m_mode[i], k, ex);
    m_done[i] = (m_mode[i] == M_CL) && (nxt == M_SB);
    if (is_timed(nxt) && nxt != m_mode[i]) begin
      m_left[i] = duration(i, nxt);
      m_cyc[i] = 0;
    end else if (is_timed(nxt)) begin
      m_cyc[i]++;
      if (m_cyc[i] == HZ) begin
        m_cyc[i] = 0;
        m_left[i]--;
      end
    end else begin
      m_left[i] = 0;
      m_cyc[i] = 0;
    end
    m_mode[i] = nxt;
  endtask

  function automatic logic [18:0] exp_vec(input int i);
    logic [2:0] code;
    logic [1:0] fan;
    case (m_mode[i])
      M_SB:    begin code = 3'b001; fan = 2'd0; end
      M_L1:    begin code = 3'b010; fan = 2'd1; end
      M_L2:    begin code = 3'b011; fan = 2'd2; end
      M_L3:    begin code = 3'b101; fan = 2'd3; end
      M_EX:    begin code = 3'b110; fan = 2'd2; end
      M_CL:    begin code = 3'b100; fan = 2'd0; end
      default: begin code = 3'b000; fan = 2'd0; end
    endcase
    return {code, fan, 6'(m_left[i] / 60), 6'(m_left[i] % 60), is_timed(m_mode[i]), m_done[i]};
  endfunction

  // ---------------- stimulus ----------------
  // Called at a negedge: drive keys for one cycle, advance model, return at next negedge.
  task automatic step(input logic [5:0] k, input logic r);
    {power_key, menu_key, clean_key, l3_key, l2_key, l1_key} = k;
    rst = r;
    @(posedge clk);
    model_step(0, k, r);
    model_step(1, k, r);
    @(negedge clk);
    {power_key, menu_key, clean_key, l3_key, l2_key, l1_key} = K_NONE;
    rst = 1'b0;
  endtask

  task automatic go_standby();
    step(K_NONE, 1'b1);
    step(K_NONE, 1'b1);
    step(K_PWR, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(6'($urandom), 1'b1);
    step(6'($urandom), 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (act[i] !== 19'd0) begin
        n_err++; $display("FAIL reset_zero dut%0d got %h want %h", i, act[i], 19'd0);
      end
    end
  endtask

  task automatic test_power_on();
    step(K_PWR, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b001 || fl[0] !== 2'd0 || rm[0] !== 6'd0 || rs[0] !== 6'd0) begin
      n_err++; $display("FAIL power_on got ms=%b fan=%0d %0d:%0d want ms=001 fan=0 0:0", ms[0], fl[0], rm[0], rs[0]);
    end
    step(K_PWR, 1'b0);
    n_vec++;
    if (act[0] !== exp_vec(0)) begin
      n_err++; $display("FAIL power_off got %h want %h", act[0], exp_vec(0));
    end
  endtask

  task automatic test_selfclean();
    int pulses = 0;
    go_standby();
    step(K_CLEAN, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b100 || rm[0] !== 6'd0 || rs[0] !== 6'd3 || tr[0] !== 1'b1) begin
      n_err++; $display("FAIL clean_entry got ms=%b %0d:%0d run=%b want ms=100 0:3 run=1", ms[0], rm[0], rs[0], tr[0]);
    end
    for (int c = 1; c <= 35; c++) begin
      step(K_NONE, 1'b0);
      if (cd[0] === 1'b1) pulses++;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_err++; $display("FAIL clean_model dut%0d cyc%0d got %h want %h", i, c, act[i], exp_vec(i));
        end
      end
      if (c == 10 || c == 20) begin
        n_vec++;
        if (rs[0] !== 6'(3 - c / 10)) begin
          n_err++; $display("FAIL clean_dec cyc%0d got sec=%0d want %0d", c, rs[0], 3 - c / 10);
        end
      end
      if (c == 30) begin
        n_vec++;
        if (ms[0] !== 3'b001 || cd[0] !== 1'b1 || rs[0] !== 6'd0) begin
          n_err++; $display("FAIL clean_end got ms=%b done=%b sec=%0d want ms=001 done=1 sec=0", ms[0], cd[0], rs[0]);
        end
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL clean_done_width got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_clean_abort();
    int pulses = 0;
    go_standby();
    step(K_CLEAN, 1'b0);
    repeat (10) step(K_NONE, 1'b0);
    n_vec++;
    if (rs[0] !== 6'd2) begin
      n_err++; $display("FAIL abort_pre got sec=%0d want 2", rs[0]);
    end
    step(K_PWR, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b000 || rm[0] !== 6'd0 || rs[0] !== 6'd0 || cd[0] !== 1'b0 || tr[0] !== 1'b0) begin
      n_err++; $display("FAIL abort got ms=%b %0d:%0d done=%b run=%b want 000 0:0 0 0", ms[0], rm[0], rs[0], cd[0], tr[0]);
    end
    repeat (30) begin
      step(K_NONE, 1'b0);
      if (cd[0] === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL abort_done got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_storm();
    go_standby();
    step(K_L3, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b101 || fl[0] !== 2'd3 || rs[0] !== 6'd2) begin
      n_err++; $display("FAIL storm_entry got ms=%b fan=%0d sec=%0d want 101 3 2", ms[0], fl[0], rs[0]);
    end
    for (int c = 1; c <= 20; c++) begin
      step((c == 7) ? K_L3 : K_NONE, 1'b0);
      n_vec++;
      if (act[0] !== exp_vec(0)) begin
        n_err++; $display("FAIL storm_model cyc%0d got %h want %h", c, act[0], exp_vec(0));
      end
    end
    n_vec++;
    if (ms[0] !== 3'b011 || fl[0] !== 2'd2 || tr[0] !== 1'b0) begin
      n_err++; $display("FAIL storm_drop got ms=%b fan=%0d run=%b want 011 2 0", ms[0], fl[0], tr[0]);
    end
  endtask

  task automatic test_exhaust();
    go_standby();
    step(K_L3, 1'b0);
    repeat (4) step(K_NONE, 1'b0);
    step(K_MENU, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b110 || fl[0] !== 2'd2 || rm[0] !== 6'd0 || rs[0] !== 6'd2 || tr[0] !== 1'b1) begin
      n_err++; $display("FAIL exhaust_entry got ms=%b fan=%0d %0d:%0d run=%b want 110 2 0:2 1", ms[0], fl[0], rm[0], rs[0], tr[0]);
    end
    for (int c = 1; c <= 20; c++) begin
      step((c == 5) ? K_L1 : K_NONE, 1'b0);
      n_vec++;
      if (act[0] !== exp_vec(0)) begin
        n_err++; $display("FAIL exhaust_model cyc%0d got %h want %h", c, act[0], exp_vec(0));
      end
    end
    n_vec++;
    if (ms[0] !== 3'b001 || fl[0] !== 2'd0) begin
      n_err++; $display("FAIL exhaust_end got ms=%b fan=%0d want 001 0", ms[0], fl[0]);
    end
  endtask

  task automatic test_priority();
    go_standby();
    step(K_L1, 1'b0);
    step(K_MENU | K_L2, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b001) begin
      n_err++; $display("FAIL prio_menu_l2 got ms=%b want 001", ms[0]);
    end
    step(K_CLEAN | K_L1, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b100 || rs[0] !== 6'd3) begin
      n_err++; $display("FAIL prio_clean_l1 got ms=%b sec=%0d want 100 3", ms[0], rs[0]);
    end
    step(K_L1, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b100 || fl[0] !== 2'd0) begin
      n_err++; $display("FAIL clean_ignores_l1 got ms=%b fan=%0d want 100 0", ms[0], fl[0]);
    end
    step(K_PWR | K_MENU | K_CLEAN, 1'b0);
    n_vec++;
    if (ms[0] !== 3'b000) begin
      n_err++; $display("FAIL prio_power got ms=%b want 000", ms[0]);
    end
  endtask

  task automatic test_minute_borrow();
    go_standby();
    step(K_CLEAN, 1'b0);
    n_vec++;
    if (rm[1] !== 6'd1 || rs[1] !== 6'd1) begin
      n_err++; $display("FAIL borrow_load got %0d:%0d want 1:1", rm[1], rs[1]);
    end
    repeat (10) step(K_NONE, 1'b0);
    n_vec++;
    if (rm[1] !== 6'd1 || rs[1] !== 6'd0) begin
      n_err++; $display("FAIL borrow_1_00 got %0d:%0d want 1:0", rm[1], rs[1]);
    end
    repeat (10) step(K_NONE, 1'b0);
    n_vec++;
    if (rm[1] !== 6'd0 || rs[1] !== 6'd59) begin
      n_err++; $display("FAIL borrow_0_59 got %0d:%0d want 0:59", rm[1], rs[1]);
    end
    step(K_NONE, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (act[i] !== 19'd0) begin
        n_err++; $display("FAIL midcount_reset dut%0d got %h want %h", i, act[i], 19'd0);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] k;
    logic r;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 6; b++) k[b] = ($urandom_range(0, 99) < 7);
      r = ($urandom_range(0, 399) == 0);
      step(k, r);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_err++; $display("FAIL random dut%0d cyc%0d keys=%b got %h want %h", i, c, k, act[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {power_key, menu_key, clean_key, l3_key, l2_key, l1_key} = K_NONE;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_OFF; m_left[i] = 0; m_cyc[i] = 0; m_done[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_power_on();
    test_selfclean();
    test_clean_abort();
    test_storm();
    test_exhaust();
    test_priority();
    test_minute_borrow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
